sd_block_loader: RTL and testbench

Sequencer that loads a run of consecutive 512-byte SD card blocks into main memory. For each block it issues CMD17 (READ_SINGLE_BLOCK) through the SPI command sender, checks the R1 response, then starts the SPI data reader for that block and waits for it to finish. It sits between the boot/load control logic and the SD card SPI datapath. It owns the data reader's `en`/`block_addr` inputs and the command sender's request port.

---
 rtl/sd_block_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_sd_block_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sd_block_loader
//  Description : Loads a run of consecutive 512-byte SD blocks into RAM.
//                Each block is fetched with CMD17 through the SPI command
//                sender, the R1 byte is checked, then the SPI data reader
//                is started for that block and waited on.
//                Optional feature macro: SD_LOAD_RETRY_EN (re-issue CMD17
//                on R1 fault or response timeout, up to RETRY_MAX times).
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_block_loader #(
    parameter logic [15:0] RESP_TIMEOUT = 16'd50000,
    parameter int unsigned RETRY_MAX    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] sd_base,
    input  logic [6:0]  mem_block,
    input  logic [7:0]  block_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [7:0]  blocks_loaded,
    output logic        cmd_start,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    input  logic        cmd_busy,
    input  logic        cmd_resp_valid,
    input  logic [7:0]  cmd_resp,
    output logic        rd_en,
    output logic [6:0]  rd_block_addr,
    input  logic        rd_done,
    input  logic        rd_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_RESP  = 3'd2,
        S_DATA  = 3'd3,
        S_WAIT  = 3'd4,
        S_NEXT  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_R1      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_READER  = 2'd3;
    localparam logic [5:0] CMD17       = 6'd17;

`ifdef SD_LOAD_RETRY_EN
    localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_MAX);
`else
    // Retry compiled out: a zero allowance sends R1/timeout faults straight to ERROR.
    localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_MAX) & 8'h00;
`endif

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [6:0]  mem_q, mem_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic [1:0]  fail_q, fail_d;
    logic        wait_first_q, wait_first_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  loaded_q, loaded_d;
    logic        cmd_start_q, cmd_start_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        rd_en_q, rd_en_d;
    logic [6:0]  rd_addr_q, rd_addr_d;

    logic [15:0] timer_inc;
    logic [7:0]  loaded_inc;
    logic [1:0]  resp_fault;
    logic        can_retry;

    // Next-state and registered-output computation for the block sequencer.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        mem_d        = mem_q;
        count_d      = count_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        fail_d       = fail_q;
        wait_first_d = 1'b0;
        done_d       = 1'b0;
        error_d      = error_q;
        err_code_d   = err_code_q;
        loaded_d     = loaded_q;
        cmd_start_d  = 1'b0;
        cmd_arg_d    = cmd_arg_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        timer_inc    = timer_q + 16'd1;
        loaded_inc   = loaded_q + 8'd1;
        resp_fault   = ERR_NONE;
        can_retry    = (retry_q != RETRY_LIMIT);

        if ((state_q != S_IDLE) && rd_error) begin
            // The data reader cannot recover, so its error overrides everything.
            if (state_q == S_ERROR) begin
                error_d    = 1'b1;
                err_code_d = ERR_READER;
                state_d    = S_IDLE;
            end else begin
                fail_d  = ERR_READER;
                state_d = S_ERROR;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (block_count != 8'd0) begin
                            base_d     = sd_base;
                            mem_d      = mem_block;
                            count_d    = block_count;
                            error_d    = 1'b0;
                            err_code_d = ERR_NONE;
                            loaded_d   = 8'd0;
                            retry_d    = 8'd0;
                            state_d    = S_CMD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (!cmd_busy) begin
                        cmd_start_d = 1'b1;
                        cmd_arg_d   = base_q + {24'd0, loaded_q};
                        timer_d     = 16'd0;
                        state_d     = S_RESP;
                    end
                end
                S_RESP: begin
                    // A response arriving on the timeout cycle still wins.
                    if (cmd_resp_valid) begin
                        if (cmd_resp == 8'h00) begin
                            // rd_en is registered here so it is high while in DATA.
                            rd_en_d   = 1'b1;
                            rd_addr_d = mem_q + loaded_q[6:0];
                            state_d   = S_DATA;
                        end else begin
                            resp_fault = ERR_R1;
                        end
                    end else if (timer_inc == RESP_TIMEOUT) begin
                        resp_fault = ERR_TIMEOUT;
                    end else begin
                        timer_d = timer_inc;
                    end
                    if (resp_fault != ERR_NONE) begin
                        if (can_retry) begin
                            retry_d = retry_q + 8'd1;
                            state_d = S_CMD;
                        end else begin
                            fail_d  = resp_fault;
                            state_d = S_ERROR;
                        end
                    end
                end
                S_DATA: begin
                    // The reader still reports done on the first WAIT cycle.
                    wait_first_d = 1'b1;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    if (rd_done && !wait_first_q) begin
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    loaded_d = loaded_inc;
                    retry_d  = 8'd0;
                    if (loaded_inc == count_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_ERROR: begin
                    error_d    = 1'b1;
                    err_code_d = fail_q;
                    state_d    = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything including pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= 32'd0;
            mem_q        <= 7'd0;
            count_q      <= 8'd0;
            timer_q      <= 16'd0;
            retry_q      <= 8'd0;
            fail_q       <= ERR_NONE;
            wait_first_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            loaded_q     <= 8'd0;
            cmd_start_q  <= 1'b0;
            cmd_arg_q    <= 32'd0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= 7'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            mem_q        <= mem_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            fail_q       <= fail_d;
            wait_first_q <= wait_first_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            loaded_q     <= loaded_d;
            cmd_start_q  <= cmd_start_d;
            cmd_arg_q    <= cmd_arg_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign blocks_loaded = loaded_q;
    assign cmd_start     = cmd_start_q;
    assign cmd_index     = CMD17;
    assign cmd_arg       = cmd_arg_q;
    assign rd_en         = rd_en_q;
    assign rd_block_addr = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_block_loader
//  Description : Scoreboard bench for sd_block_loader with behavioural
//                command-sender and data-reader responders.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_block_loader;

    typedef struct packed {
        logic       e_done;
        logic       e_error;
        logic [1:0] e_code;
        logic [7:0] e_loaded;
    } end_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] sd_base;
    logic [6:0]  mem_block;
    logic [7:0]  block_count;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [7:0]  blocks_loaded;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_busy, cmd_resp_valid;
    logic [7:0]  cmd_resp;
    logic        rd_en;
    logic [6:0]  rd_block_addr;
    logic        rd_done, rd_error;
    logic        rbusy, inject_rd_err;

    logic [31:0] exp_cmd[$];
    logic [6:0]  exp_rd[$];
    end_t        exp_end[$];
    logic [7:0]  resp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sd_block_loader #(.RESP_TIMEOUT(16'd100), .RETRY_MAX(2)) dut (
        .clk(clk), .reset(reset), .start(start), .sd_base(sd_base),
        .mem_block(mem_block), .block_count(block_count), .busy(busy),
        .done(done), .error(error), .err_code(err_code),
        .blocks_loaded(blocks_loaded), .cmd_start(cmd_start),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_busy(cmd_busy),
        .cmd_resp_valid(cmd_resp_valid), .cmd_resp(cmd_resp), .rd_en(rd_en),
        .rd_block_addr(rd_block_addr), .rd_done(rd_done), .rd_error(rd_error)
    );

    assign rd_done = !rbusy && !rd_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL unexpected %s: got %h required none", name, act);
    endtask

    // Command sender model: busy after a request, R1 two cycles later if queued.
    initial begin
        cmd_busy = 1'b0; cmd_resp_valid = 1'b0; cmd_resp = 8'h00;
        forever begin
            @(posedge clk);
            if (cmd_start === 1'b1) begin
                #1 cmd_busy = 1'b1;
                repeat (2) @(posedge clk);
                if (resp_q.size() != 0) begin
                    #1 cmd_resp = resp_q.pop_front(); cmd_resp_valid = 1'b1;
                    @(posedge clk);
                    #1 cmd_resp_valid = 1'b0; cmd_busy = 1'b0;
                end else begin
                    #1 cmd_busy = 1'b0;
                end
            end
        end
    end

    // Data reader model: five busy cycles per block, optional sticky error.
    initial begin
        rbusy = 1'b0; rd_error = 1'b0;
        forever begin
            @(posedge clk);
            if (rd_en === 1'b1) begin
                #1 rbusy = 1'b1;
                repeat (3) @(posedge clk);
                if (inject_rd_err) begin
                    #1 rd_error = 1'b1;
                end
                repeat (2) @(posedge clk);
                #1 rbusy = 1'b0;
            end else if (!inject_rd_err && rd_error) begin
                #1 rd_error = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pulse or ends a run.
    initial begin : monitor
        logic busy_prev, rd_en_prev;
        end_t e;
        busy_prev = 1'b0;
        rd_en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_start === 1'b1) begin
                check("cmd_index", 32'(cmd_index), 32'd17);
                if (exp_cmd.size() == 0) unexpected("cmd_start", cmd_arg);
                else check("cmd_arg", cmd_arg, exp_cmd.pop_front());
            end
            if (rd_en === 1'b1) begin
                check("rd_en one cycle", 32'(rd_en_prev), 32'd0);
                if (exp_rd.size() == 0) unexpected("rd_en", 32'(rd_block_addr));
                else check("rd_block_addr", 32'(rd_block_addr), 32'(exp_rd.pop_front()));
            end
            if (done === 1'b1 || (busy_prev === 1'b1 && busy === 1'b0)) begin
                if (exp_end.size() == 0) begin
                    unexpected("run end", {done, error, err_code, blocks_loaded});
                end else begin
                    e = exp_end.pop_front();
                    check("end done", 32'(done), 32'(e.e_done));
                    check("end error", 32'(error), 32'(e.e_error));
                    check("end err_code", 32'(err_code), 32'(e.e_code));
                    check("end blocks_loaded", 32'(blocks_loaded), 32'(e.e_loaded));
                end
            end
            busy_prev  = busy;
            rd_en_prev = rd_en;
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [6:0] m, input logic [7:0] n);
        @(posedge clk);
        #1 sd_base = b; mem_block = m; block_count = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
        repeat (12) @(posedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        reset = 1'b1; start = 1'b0; sd_base = 32'd0; mem_block = 7'd0;
        block_count = 8'd0; inject_rd_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset err_code", 32'(err_code), 32'd0);
        check("reset blocks_loaded", 32'(blocks_loaded), 32'd0);
        check("reset cmd_start", 32'(cmd_start), 32'd0);
        check("reset cmd_arg", cmd_arg, 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset rd_block_addr", 32'(rd_block_addr), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Zero-length request: done next cycle, never busy, no command.
        exp_end.push_back('{1'b1, 1'b0, 2'd0, 8'd0});
        do_start(32'h55, 7'd9, 8'd0);
        @(negedge clk);
        check("zero done pulse", 32'(done), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("zero done width", 32'(done), 32'd0);
        check("zero busy later", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);

        // Three good blocks.
        resp_q = '{8'h00, 8'h00, 8'h00};
        exp_cmd = '{32'h100, 32'h101, 32'h102};
        exp_rd = '{7'd5, 7'd6, 7'd7};
        exp_end.push_back('{1'b1, 1'b0, 2'd0, 8'd3});
        do_start(32'h100, 7'd5, 8'd3);
        wait_idle("run3 finishes");

        // Wrap of both the SD address and the RAM block index.
        resp_q = '{8'h00, 8'h00};
        exp_cmd = '{32'hFFFF_FFFF, 32'h0000_0000};
        exp_rd = '{7'd127, 7'd0};
        exp_end.push_back('{1'b1, 1'b0, 2'd0, 8'd2});
        do_start(32'hFFFF_FFFF, 7'd127, 8'd2);
        wait_idle("wrap finishes");

        // Nonzero R1 on block 1 of 3.
`ifdef SD_LOAD_RETRY_EN
        resp_q = '{8'h00, 8'h05, 8'h00, 8'h00};
        exp_cmd = '{32'h200, 32'h201, 32'h201, 32'h202};
        exp_rd = '{7'd0, 7'd1, 7'd2};
        exp_end.push_back('{1'b1, 1'b0, 2'd0, 8'd3});
`else
        resp_q = '{8'h00, 8'h05};
        exp_cmd = '{32'h200, 32'h201};
        exp_rd = '{7'd0};
        exp_end.push_back('{1'b0, 1'b1, 2'd1, 8'd1});
`endif
        do_start(32'h200, 7'd0, 8'd3);
        wait_idle("r1 fault finishes");

        // No response at all: timeout.
`ifdef SD_LOAD_RETRY_EN
        exp_cmd = '{32'h300, 32'h300, 32'h300};
`else
        exp_cmd = '{32'h300};
`endif
        exp_end.push_back('{1'b0, 1'b1, 2'd2, 8'd0});
        do_start(32'h300, 7'd10, 8'd1);
        k = 0;
        @(negedge clk);
        while (cmd_start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout cmd issued", 32'(k < 50), 32'd1);
        k = 0;
        while (busy !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
`ifndef SD_LOAD_RETRY_EN
        check("timeout latency", 32'(k), 32'd101);
`endif
        check("timeout error set", 32'(error), 32'd1);
        repeat (4) @(posedge clk);

        // New start clears the sticky error.
        resp_q = '{8'h00};
        exp_cmd = '{32'h400};
        exp_rd = '{7'd3};
        exp_end.push_back('{1'b1, 1'b0, 2'd0, 8'd1});
        do_start(32'h400, 7'd3, 8'd1);
        @(negedge clk);
        check("restart clears error", 32'(error), 32'd0);
        check("restart clears err_code", 32'(err_code), 32'd0);
        wait_idle("restart finishes");

        // Data reader error during WAIT of block 0, never retried.
        inject_rd_err = 1'b1;
        resp_q = '{8'h00};
        exp_cmd = '{32'h500};
        exp_rd = '{7'd20};
        exp_end.push_back('{1'b0, 1'b1, 2'd3, 8'd0});
        do_start(32'h500, 7'd20, 8'd2);
        wait_idle("reader error finishes");
        inject_rd_err = 1'b0;
        repeat (4) @(posedge clk);

        // Reset while in DATA (the rd_en cycle).
        resp_q = '{8'h00};
        exp_cmd = '{32'h600};
        exp_rd = '{7'd0};
        exp_end.push_back('{1'b0, 1'b0, 2'd0, 8'd0});
        do_start(32'h600, 7'd0, 8'd2);
        k = 0;
        @(negedge clk);
        while (rd_en !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach DATA", 32'(k < 100), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset error", 32'(error), 32'd0);
        check("mid reset err_code", 32'(err_code), 32'd0);
        check("mid reset blocks_loaded", 32'(blocks_loaded), 32'd0);
        check("mid reset cmd_start", 32'(cmd_start), 32'd0);
        check("mid reset cmd_arg", cmd_arg, 32'd0);
        check("mid reset rd_en", 32'(rd_en), 32'd0);
        check("mid reset rd_block_addr", 32'(rd_block_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);

        check("leftover cmd expectations", 32'(exp_cmd.size()), 32'd0);
        check("leftover rd expectations", 32'(exp_rd.size()), 32'd0);
        check("leftover end expectations", 32'(exp_end.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
